serial_receiver: RTL

Asynchronous serial (UART-style) receiver that deserializes the chip's `Dout` line back into bytes. It serves as the bench-side checker for the chip's serial output and as the on-chip receive path for loopback and host-command input. It produces one byte per frame through a valid/ready holding register and flags framing and overrun errors. The frame format is 8N1 by default, with optional even parity.

---
 rtl/serial_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// UART-style serial receiver with mid-bit sampling and a valid/ready holding register.
// Optional even parity is compiled in when KBT_RX_PARITY_EN is defined.
module serial_receiver #(
  parameter int unsigned BIT_CYCLES = 87,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Din,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxReady,
  output logic                 FrameError,
  output logic                 Overrun,
  output logic                 ParityError
);

  localparam int unsigned   CW        = $clog2(BIT_CYCLES);
  localparam int unsigned   IW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef KBT_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e               state_q;
  logic                 sync1_q;
  logic                 ds_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 par_err_q;
  logic                 par_ok_c;
  logic                 xfer_c;

  assign xfer_c = rx_valid_q & RxReady;

  // Two-flop synchronizer; idle-high reset value so reset never looks like a start bit.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      ds_q    <= 1'b1;
    end else begin
      sync1_q <= Din;
      ds_q    <= sync1_q;
    end
  end

`ifdef KBT_RX_PARITY_EN
  logic par_bad_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      par_bad_q <= 1'b0;
    end else if (state_q == S_PARITY && cnt_q == BIT_LAST) begin
      par_bad_q <= ds_q ^ (^shift_q);
    end
  end

  assign par_ok_c = ~par_bad_q;
`else
  assign par_ok_c = 1'b1;
`endif

  // Frame FSM, bit timing, shift register, holding register and error pulses.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;
      if (xfer_c) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!ds_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= ds_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {ds_q, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
`ifdef KBT_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

`ifdef KBT_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            par_err_q <= ~par_ok_c;
            if (!ds_q) begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end else begin
              state_q <= S_IDLE;
              if (par_ok_c) begin
                // A same-cycle consumer transfer frees the register for the new byte.
                if (rx_valid_q && !RxReady) begin
                  overrun_q <= 1'b1;
                end else begin
                  rx_data_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                end
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_WAIT_HIGH: begin
          if (ds_q) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RxData      = rx_data_q;
  assign RxValid     = rx_valid_q;
  assign FrameError  = frame_err_q;
  assign Overrun     = overrun_q;
  assign ParityError = par_err_q;

endmodule
